rv_fetch_unit: RTL and testbench

RV_FETCH_UNIT -- requirements
Module: rv_fetch_unit

---
 rtl/rv_fetch_pkg.sv | 16 +
 rtl/rv_fetch_fifo.sv | 55 +++++
 rtl/rv_fetch_unit.sv | 128 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared constants and queue-entry type for the instruction fetch unit.
package rv_fetch_pkg;

  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PC_MAX_W   = 64;

  localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;

  // pc is sized for the widest supported XLEN; narrower builds use the low bits
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [ILEN-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
module rv_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order response queue, redirect flush.
// Define FETCH_BYPASS_EN to forward a kept response straight to the head when the queue is empty.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   im_req_valid,
  input  logic                   im_req_ready,
  output logic [XLEN-1:0]        im_addr,
  input  logic                   im_resp_valid,
  input  logic [ILEN-1:0]        im_dout,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [ILEN-1:0]        inst,
  output logic [XLEN-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [XLEN-1:0] w_redirect_pc;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [$bits(fetch_entry_t)-1:0] w_fifo_rdata;
  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;
  logic            w_credit;
  logic            w_accept;
  logic            w_keep;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_redirect_pc = redirect_pc & ALIGN_MASK;
  assign w_head        = fetch_entry_t'(w_fifo_rdata);

  // queued entries plus in-flight requests bound the worst-case fill level
  assign w_credit     = !w_fifo_full &&
                        (({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
  assign im_req_valid = !rst && !redirect && w_credit;
  assign im_addr      = r_fetch_pc;
  assign w_accept     = im_req_valid && im_req_ready;
  assign w_keep       = !rst && !redirect && im_resp_valid && (r_drop == '0);
  assign count        = rst ? '0 : w_fifo_count;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_keep && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    inst_valid    = 1'b0;
    inst          = NOP_INST;
    inst_pc       = '0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_entry.pc    = PC_MAX_W'(r_resp_pc);
    w_entry.inst  = im_dout;
    if (!rst) begin
      if (!w_fifo_empty) begin
        inst_valid = 1'b1;
        inst       = w_head.inst;
        inst_pc    = w_head.pc[XLEN-1:0];
      end else if (w_bypass) begin
        inst_valid = 1'b1;
        inst       = im_dout;
        inst_pc    = r_resp_pc;
      end
      if (!redirect) begin
        w_pop  = !w_fifo_empty && !stall;
        // a bypassed response consumed this cycle never enters the queue
        w_push = w_keep && !(w_bypass && !stall);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC & ALIGN_MASK;
      r_resp_pc     <= RESET_PC & ALIGN_MASK;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= r_outstanding - CW'(im_resp_valid);
      r_drop        <= r_outstanding - CW'(im_resp_valid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_keep)   r_resp_pc  <= r_resp_pc + PC_STEP;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(im_resp_valid);
      if (im_resp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit with an in-order latency memory model and an instruction scoreboard.
module tb_rv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_addr;
  logic        im_resp_valid;
  logic [31:0] im_dout;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  rv_fetch_unit #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .im_req_valid  (im_req_valid),
    .im_req_ready  (im_req_ready),
    .im_addr       (im_addr),
    .im_resp_valid (im_resp_valid),
    .im_dout       (im_dout),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .count         (count)
  );

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;

  mreq_t mq[$];
  exp_t  sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat    = 1;
  int n_acc  = 0;

  logic [63:0] o_rv, o_addr, o_iv, o_inst, o_pc, o_cnt, o_resp;
  logic        got_pop;
  logic [63:0] first_pop_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h00500093 + (a[31:0] << 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic acc, pop;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      im_resp_valid = 1'b1;
      im_dout       = mem_word(mq[0].addr);
    end else begin
      im_resp_valid = 1'b0;
      im_dout       = 32'hDEADBEEF;
    end
    @(negedge clk);
    o_rv   = 64'(im_req_valid);
    o_addr = im_addr;
    o_iv   = 64'(inst_valid);
    o_inst = 64'(inst);
    o_pc   = inst_pc;
    o_cnt  = 64'(count);
    o_resp = 64'(im_resp_valid);
    acc    = im_req_valid && im_req_ready;
    pop    = inst_valid && !stall && !redirect;
    if (redirect) sb.delete();
    if (im_resp_valid && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{im_addr, cyc + lat});
      sb.push_back('{im_addr, mem_word(im_addr)});
      n_acc++;
    end
    if (pop) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_pc", o_pc, e.pc);
        chk("pop_inst", o_inst, 64'(e.inst));
      end
      if (!got_pop) begin
        got_pop      = 1'b1;
        first_pop_pc = o_pc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    stall         = 1'b0;
    im_req_ready  = 1'b1;
    im_resp_valid = 1'b0;
    im_dout       = '0;
    mq.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_valid", 64'(im_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_inst_nop", 64'(inst), 64'h13);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cyc     = 0;
    n_acc   = 0;
    got_pop = 1'b0;
  endtask

  initial begin
    // basic stream with 1-cycle memory
    lat = 1;
    do_reset();
    tick();
    chk("t1_rv0", o_rv, 64'd1);
    chk("t1_addr0", o_addr, 64'h0);
    tick();
    chk("t1_addr1", o_addr, 64'h4);
`ifdef FETCH_BYPASS_EN
    chk("t1_bypass_valid", o_iv, 64'd1);
    chk("t1_bypass_inst", o_inst, 64'h00500093);
    chk("t1_bypass_pc", o_pc, 64'h0);
`else
    chk("t1_no_early_valid", o_iv, 64'd0);
`endif
    tick();
    chk("t1_addr2", o_addr, 64'h8);
    chk("t1_valid2", o_iv, 64'd1);
`ifdef FETCH_BYPASS_EN
    chk("t1_pc2", o_pc, 64'h4);
`else
    chk("t1_pc2", o_pc, 64'h0);
`endif
    repeat (10) tick();

    // stall held: credit limits requests to DEPTH
    lat = 1;
    do_reset();
    stall = 1'b1;
    repeat (12) tick();
    chk("t2_req_count", 64'(n_acc), 64'd4);
    chk("t2_count_full", o_cnt, 64'd4);
    chk("t2_rv_blocked", o_rv, 64'd0);
    stall = 1'b0;
    repeat (12) tick();
    chk("t2_got_pop", 64'(got_pop), 64'd1);
    chk("t2_first_pc", first_pop_pc, 64'h0);

    // redirect with three late responses in flight; target low bits ignored
    lat = 3;
    do_reset();
    repeat (3) tick();
    chk("t3_outstanding", 64'(n_acc), 64'd3);
    redirect    = 1'b1;
    redirect_pc = 64'h1003;
    tick();
    chk("t3_rv_in_redirect", o_rv, 64'd0);
    chk("t3_resp_in_redirect", o_resp, 64'd1);
    redirect = 1'b0;
    tick();
    chk("t3_rv_after", o_rv, 64'd1);
    chk("t3_addr_after", o_addr, 64'h1000);
    chk("t3_count_after", o_cnt, 64'd0);
    got_pop = 1'b0;
    repeat (20) tick();
    chk("t3_got_pop", 64'(got_pop), 64'd1);
    chk("t3_first_pc", first_pop_pc, 64'h1000);

    // redirect colliding with pop and response
    lat = 1;
    do_reset();
    repeat (6) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    chk("t4_resp_in_redirect", o_resp, 64'd1);
`ifndef FETCH_BYPASS_EN
    chk("t4_head_valid", o_iv, 64'd1);
`endif
    redirect = 1'b0;
    tick();
    chk("t4_count_zero", o_cnt, 64'd0);
    chk("t4_valid_zero", o_iv, 64'd0);
    chk("t4_addr", o_addr, 64'h2000);
    got_pop = 1'b0;
    repeat (8) tick();
    chk("t4_first_pc", first_pop_pc, 64'h2000);

    // memory backpressure: address holds until accepted
    lat = 1;
    do_reset();
    tick();
    tick();
    im_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_addr_hold", o_addr, 64'h8);
      chk("t5_rv_hold", o_rv, 64'd1);
    end
    im_req_ready = 1'b1;
    tick();
    chk("t5_accept_addr", o_addr, 64'h8);
    chk("t5_accept_count", 64'(n_acc), 64'd3);
    tick();
    chk("t5_next_addr", o_addr, 64'hC);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
